hazard_scoreboard_unit: RTL and testbench

//  Parametrised successor to the 5-stage hazard detector: per-register countdown scoreboard in ID.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/reg_ready_counter.sv | 38 +++
 rtl/hazard_scoreboard_unit.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Stall-cause encodings and sizing helper for the hazard scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_RAW   = 2'd1;
    localparam logic [1:0] CAUSE_ECALL = 2'd2;
    localparam logic [1:0] CAUSE_HOLD  = 2'd3;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_ready_counter.sv
// ============================================================================
// Module   : reg_ready_counter
// Brief    : Per-register countdown until a pending result becomes readable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_ready_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec_en,
    output logic [CW-1:0] cnt,
    output logic          nonzero
);

    logic [CW-1:0] r_cnt;

    // A new writer replaces whatever was pending: youngest writer wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt     = r_cnt;
    assign nonzero = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module   : hazard_scoreboard_unit
// Brief    : ID-stage countdown scoreboard producing stall/freeze controls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int RA_W      = 5,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int FWD_SLACK = 1,
    parameter int ECALL_REG = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic                pipe_hold,
    input  logic [RA_W-1:0]     id_rs1,
    input  logic [RA_W-1:0]     id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_is_ecall,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    output logic                pc_write,
    output logic                IF_ID_write,
    output logic                is_stall,
    output logic [1:0]          stall_cause,
    output logic [31:0]         stall_count,
    output logic [NUM_REGS-1:0] pending_mask
);

    localparam int CW = clog2(((ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT) + 1);

    localparam logic [CW-1:0] c_alu_val   = CW'(ALU_LAT);
    localparam logic [CW-1:0] c_load_val  = CW'(LOAD_LAT);
    localparam logic [31:0]   c_fwd_slack = 32'(FWD_SLACK);

    logic [CW-1:0] w_cnt [NUM_REGS];
    logic [CW-1:0] w_load_val;
    logic          w_live;
    logic          w_raw;
    logic          w_ecl;
    logic          w_issue;
    logic          w_dec_en;
    logic [31:0]   r_stall_count;

    assign w_live     = id_valid & ~id_flush;
    // Zero-extend before comparing so a slack wider than the counter never stalls.
    assign w_raw      = w_live &
                        ((id_use_rs1 & (32'(w_cnt[id_rs1]) > c_fwd_slack)) |
                         (id_use_rs2 & (32'(w_cnt[id_rs2]) > c_fwd_slack)));
    assign w_ecl      = w_live & id_is_ecall & (w_cnt[ECALL_REG] != '0);
    assign w_issue    = w_live & ~pipe_hold & ~w_raw & ~w_ecl;
    assign w_dec_en   = ~pipe_hold;
    assign w_load_val = id_is_load ? c_load_val : c_alu_val;

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r = r + 1) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_cnt[r]        = '0;
                assign pending_mask[r] = 1'b0;
            end else begin : g_ctr
                logic w_load;
                assign w_load = w_issue & id_reg_write & (id_rd == RA_W'(r));

                reg_ready_counter #(
                    .CW(CW)
                ) u_ctr (
                    .clk      (clk),
                    .reset    (reset),
                    .load     (w_load),
                    .load_val (w_load_val),
                    .dec_en   (w_dec_en),
                    .cnt      (w_cnt[r]),
                    .nonzero  (pending_mask[r])
                );
            end
        end
    endgenerate

    always_comb begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        is_stall    = 1'b0;
        stall_cause = CAUSE_NONE;
        if (pipe_hold) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            stall_cause = CAUSE_HOLD;
        end else if (w_raw) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            is_stall    = 1'b1;
            stall_cause = CAUSE_RAW;
        end else if (w_ecl) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            is_stall    = 1'b1;
            stall_cause = CAUSE_ECALL;
        end
    end

    // Held cycles are excluded: they are memory stalls, not data hazards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (~pipe_hold && (w_raw || w_ecl) && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Brief    : Directed checks of the hazard scoreboard (default and slow builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_flush, pipe_hold;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_is_ecall, id_reg_write, id_is_load;

    logic        pc_write, IF_ID_write, is_stall;
    logic [1:0]  stall_cause;
    logic [31:0] stall_count, pending_mask;

    logic        b_pc_write, b_IF_ID_write, b_is_stall;
    logic [1:0]  b_stall_cause;
    logic [31:0] b_stall_count, b_pending_mask;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count;

    always #5 clk = ~clk;

    hazard_scoreboard_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .pipe_hold(pipe_hold), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_ecall(id_is_ecall),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .is_stall(is_stall),
        .stall_cause(stall_cause), .stall_count(stall_count), .pending_mask(pending_mask)
    );

    hazard_scoreboard_unit #(
        .ALU_LAT(3), .LOAD_LAT(3), .FWD_SLACK(0)
    ) u_dut_slow (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .pipe_hold(pipe_hold), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_ecall(id_is_ecall),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .pc_write(b_pc_write), .IF_ID_write(b_IF_ID_write), .is_stall(b_is_stall),
        .stall_cause(b_stall_cause), .stall_count(b_stall_count), .pending_mask(b_pending_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic ec,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_is_ecall = ec; id_rd = rd; id_reg_write = wr; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check the current ID-stage decision mid-cycle, then let one edge pass.
    task automatic cyc(input string tag, input logic stall, input logic [1:0] cause);
        @(negedge clk);
        check({tag, ".stall"}, {31'b0, is_stall}, {31'b0, stall});
        check({tag, ".cause"}, {30'b0, stall_cause}, {30'b0, cause});
        check({tag, ".pc"}, {31'b0, pc_write}, {31'b0, cause == 2'd0});
        check({tag, ".ifid"}, {31'b0, IF_ID_write}, {31'b0, cause == 2'd0});
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; id_flush = 1'b0; pipe_hold = 1'b0;
        idle();
        exp_count = 0;
        #2;
        check("rst.pc", {31'b0, pc_write}, 32'd1);
        check("rst.ifid", {31'b0, IF_ID_write}, 32'd1);
        check("rst.stall", {31'b0, is_stall}, 32'd0);
        check("rst.cause", {30'b0, stall_cause}, 32'd0);
        check("rst.count", stall_count, 32'd0);
        check("rst.mask", pending_mask, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Load-use: one RAW bubble, then the reader issues.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("lw5", 0, 2'd0);
        check("lw5.mask", pending_mask, 32'h0000_0020);
        set_id(1, 5'd5, 1, 5'd1, 1, 0, 5'd6, 1, 0); cyc("ld_use", 1, 2'd1);
        exp_count++;
        cyc("ld_use_iss", 0, 2'd0);
        idle(); cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);
        check("drain.mask", pending_mask, 32'd0);
        check("count1", stall_count, exp_count);

        // ALU->ECALL one stall, load->ECALL two stalls.
        set_id(1, 5'd0, 1, 5'd0, 0, 0, 5'd17, 1, 0); cyc("addi17", 0, 2'd0);
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0); cyc("ecl_alu", 1, 2'd2);
        exp_count++;
        cyc("ecl_alu_iss", 0, 2'd0);
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd17, 1, 1); cyc("lw17", 0, 2'd0);
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0); cyc("ecl_ld1", 1, 2'd2);
        cyc("ecl_ld2", 1, 2'd2);
        exp_count += 2;
        cyc("ecl_ld_iss", 0, 2'd0);
        check("count2", stall_count, exp_count);
        idle(); cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);

        // Hold freezes the countdown; RAW still pending after release.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("lw5h", 0, 2'd0);
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) cyc("hold", 0, 2'd3);
        check("hold.mask", pending_mask, 32'h0000_0020);
        pipe_hold = 1'b0;
        cyc("hold_raw", 1, 2'd1);
        exp_count++;
        cyc("hold_iss", 0, 2'd0);
        check("count3", stall_count, exp_count);
        idle(); cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);

        // WAW: ALU writer after a load shortens the wait.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("waw_lw", 0, 2'd0);
        set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd5, 1, 0); cyc("waw_addi", 0, 2'd0);
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0); cyc("waw_use", 0, 2'd0);
        idle(); cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);

        // WAW: load after an ALU writer lengthens the wait.
        set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd5, 1, 0); cyc("waw2_addi", 0, 2'd0);
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("waw2_lw", 0, 2'd0);
        set_id(1, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0); cyc("waw2_use", 1, 2'd1);
        exp_count++;
        cyc("waw2_iss", 0, 2'd0);
        idle(); cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);

        // x0 is never tracked.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd0, 1, 1); cyc("wr_x0", 0, 2'd0);
        check("x0.mask", pending_mask, 32'd0);
        set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0); cyc("rd_x0", 0, 2'd0);

        // Flushed dependent neither stalls nor issues.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("fl_lw", 0, 2'd0);
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd7, 1, 0);
        id_flush = 1'b1;
        cyc("flush", 0, 2'd0);
        id_flush = 1'b0;
        idle();
        check("flush.mask", pending_mask, 32'h0000_0020);
        check("count4", stall_count, exp_count);
        cyc("idle", 0, 2'd0); cyc("idle", 0, 2'd0);

        // Asynchronous reset in the middle of a stall.
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd5, 1, 1); cyc("ar_lw", 0, 2'd0);
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        @(negedge clk);
        check("ar.pre_stall", {31'b0, is_stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar.pc", {31'b0, pc_write}, 32'd1);
        check("ar.ifid", {31'b0, IF_ID_write}, 32'd1);
        check("ar.stall", {31'b0, is_stall}, 32'd0);
        check("ar.cause", {30'b0, stall_cause}, 32'd0);
        check("ar.count", stall_count, 32'd0);
        check("ar.mask", pending_mask, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();

        // Slow build without forwarding: ALU->use costs three stalls.
        set_id(1, 5'd1, 1, 5'd0, 0, 0, 5'd5, 1, 0); cyc("slow_addi", 0, 2'd0);
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("slow.stall%0d", i), {31'b0, b_is_stall}, {31'b0, i < 3});
            check($sformatf("slow.cause%0d", i), {30'b0, b_stall_cause}, (i < 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        check("slow.count", b_stall_count, 32'd3);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
